instr_fetch_queue: RTL

Fetch stage sitting directly downstream of the program counter register: takes the current PC, issues reads to the synchronous instruction memory, and buffers returned instructions with their PCs in a small FIFO for decode. Owns the PC advance enable (PC_WRITE), so the PC moves only when a fetch is actually issued or a redirect occurs. Decouples decode back-pressure from fetch and discards wrong-path instructions on a branch/jump flush.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/instr_fetch_queue.sv | 75 +++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fetch_entry_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous show-ahead FIFO of fetch entries with push/pop/clear and occupancy count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     clear,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear) begin
            // Storage is left stale; only the pointers matter after a redirect.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues instruction memory reads from the PC under a credit check and
// buffers returned {pc, ir} pairs for decode; owns the PC advance enable.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] PC_ADDR,
    output logic        PC_WRITE,
    input  logic        FLUSH,
    output logic        MEM_RDEN,
    output logic [31:0] MEM_ADDR,
    input  logic [31:0] MEM_DOUT,
    output logic        IR_VALID,
    output logic [31:0] IR,
    output logic [31:0] IR_PC,
    input  logic        IR_READY
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] count;
    logic [CW:0]   used;
    logic          inflight_q;
    logic [31:0]   inflight_pc_q;
    logic          issue;
    logic          push;
    logic          pop;
    fetch_entry_t  push_data;
    fetch_entry_t  head;

    // An outstanding read already owns a slot, so it counts against the credit.
    assign used  = {1'b0, count} + {{CW{1'b0}}, inflight_q};
    assign issue = !RESET && !FLUSH && (used < (CW + 1)'(DEPTH));

    assign MEM_RDEN = issue;
    assign MEM_ADDR = PC_ADDR;
    assign PC_WRITE = issue || (FLUSH && !RESET);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= PC_ADDR;
            end
        end
    end

    assign push      = inflight_q && !FLUSH && !RESET;
    assign push_data = '{pc: inflight_pc_q, ir: MEM_DOUT};

    assign IR_VALID = (count != '0) && !FLUSH && !RESET;
    assign pop      = IR_VALID && IR_READY;
    assign IR       = head.ir;
    assign IR_PC    = head.pc;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .clear     (FLUSH),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

endmodule
